wb_arbiter: RTL and testbench

Writeback arbiter sitting directly upstream of the register file write port (`wr_en`/`wr_addr`/`wr_data`). It merges two result sources onto that single port. The first is the in-order ALU/load pipe. The second is the multi-cycle mul/div unit, which completes out of order relative to the pipe. It buffers one mul/div result, prevents starvation of that buffered result, and resolves write-after-write (WAW) collisions on the same destination.

---
 rtl/wb_arbiter_if.sv | 24 ++
 rtl/wb_arbiter.sv | 63 ++++++
 tb/tb_wb_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: pipe, mul/div, buffer-status and register-file write signals of the writeback arbiter
interface wb_arbiter_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_ready;
  logic              md_valid;
  logic [ADDR_W-1:0] md_rd;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_rd;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  modport master (
    output pipe_valid, pipe_rd, pipe_data, md_valid, md_rd, md_data,
    input  pipe_ready, md_ready, buf_valid, buf_rd, wr_en, wr_addr, wr_data
  );
  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, md_valid, md_rd, md_data,
    output pipe_ready, md_ready, buf_valid, buf_rd, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the in-order pipe and a one-entry mul/div buffer onto the register file write port
module wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         nrst,
  wb_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_rd_q, buf_rd_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [CW-1:0]     starve_cnt_q, starve_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              grant_md, pipe_ready, pipe_wr, md_acc, supersede, md_wr;
  always_comb begin
    grant_md     = buf_valid_q && (!bus.pipe_valid || bus.pipe_rd == '0 || starve_cnt_q == CW'(STARVE_LIMIT));
    pipe_ready   = nrst && !(grant_md && bus.pipe_valid && bus.pipe_rd != '0);
    pipe_wr      = bus.pipe_valid && pipe_ready && bus.pipe_rd != '0;
    md_acc       = bus.md_valid && !buf_valid_q;
    // the pipe result is younger, so a same-destination buffered result is dead
    supersede    = pipe_wr && buf_valid_q && bus.pipe_rd == buf_rd_q;
    md_wr        = grant_md && buf_rd_q != '0;
    wr_en_d      = pipe_wr || md_wr;
    wr_addr_d    = pipe_wr ? bus.pipe_rd : md_wr ? buf_rd_q : wr_addr_q;
    wr_data_d    = pipe_wr ? bus.pipe_data : md_wr ? buf_data_q : wr_data_q;
    buf_valid_d  = md_acc ? 1'b1 : (grant_md || supersede) ? 1'b0 : buf_valid_q;
    buf_rd_d     = md_acc ? bus.md_rd : buf_rd_q;
    buf_data_d   = md_acc ? bus.md_data : buf_data_q;
    starve_cnt_d = (!buf_valid_q || grant_md || supersede) ? '0 :
                   (pipe_wr && starve_cnt_q != CW'(STARVE_LIMIT)) ? starve_cnt_q + CW'(1) : starve_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      buf_valid_q  <= 1'b0;
      buf_rd_q     <= '0;
      buf_data_q   <= '0;
      starve_cnt_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      buf_valid_q  <= buf_valid_d;
      buf_rd_q     <= buf_rd_d;
      buf_data_q   <= buf_data_d;
      starve_cnt_q <= starve_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end
  assign bus.pipe_ready = pipe_ready;
  assign bus.md_ready   = ~buf_valid_q;
  assign bus.buf_valid  = buf_valid_q;
  assign bus.buf_rd     = buf_rd_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized and directed stimulus against a transaction-level writeback model with a write scoreboard
module tb_wb_arbiter;
  localparam int DW = 32, AW = 5, SL = 4;
  typedef struct {int cyc; logic [AW-1:0] rd; logic [DW-1:0] d;} wr_t;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;
  wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(SL)) dut (.clk(clk), .nrst(nrst), .bus(bus));
  wr_t exp_q[$];
  int vectors = 0, errors = 0, cyc = 0;
  bit mon_on = 0;
  bit mb_v = 0;
  logic [AW-1:0] mb_rd;
  logic [DW-1:0] mb_d;
  int losses = 0;
  bit p_acc = 0, md_acc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  task automatic drive(bit pv, logic [AW-1:0] prd, logic [DW-1:0] pd, bit mv, logic [AW-1:0] mrd, logic [DW-1:0] md);
    bus.pipe_valid = pv; bus.pipe_rd = prd; bus.pipe_data = pd;
    bus.md_valid = mv; bus.md_rd = mrd; bus.md_data = md;
  endtask
  // model: one pending mul/div result that loses to pipe writes until it has lost SL times
  task automatic step();
    bit pw, mw, pr, mr;
    @(negedge clk);
    p_acc = 0; md_acc = 0;
    if (!nrst) begin
      chk("pipe_ready_in_reset", 64'(bus.pipe_ready), 0);
      mb_v = 0; losses = 0;
    end else begin
      pw = bus.pipe_valid && bus.pipe_rd != 0;
      mw = mb_v && (!pw || losses == SL);
      pr = !(mw && pw);
      mr = !mb_v;
      chk("pipe_ready", 64'(bus.pipe_ready), 64'(pr));
      chk("md_ready", 64'(bus.md_ready), 64'(mr));
      chk("buf_valid", 64'(bus.buf_valid), 64'(mb_v));
      if (mb_v) chk("buf_rd", 64'(bus.buf_rd), 64'(mb_rd));
      if (pw && pr) begin
        exp_q.push_back('{cyc + 1, bus.pipe_rd, bus.pipe_data});
        if (mb_v && bus.pipe_rd == mb_rd) begin mb_v = 0; losses = 0; end
        else if (mb_v) losses++;
      end else if (mw) begin
        if (mb_rd != 0) exp_q.push_back('{cyc + 1, mb_rd, mb_d});
        mb_v = 0; losses = 0;
      end
      if (bus.md_valid && mr) begin mb_v = 1; mb_rd = bus.md_rd; mb_d = bus.md_data; losses = 0; end
      p_acc = bus.pipe_valid && pr;
      md_acc = bus.md_valid && mr;
    end
    @(posedge clk);
    #1;
  endtask
  function automatic logic [AW-1:0] pick();
    return $urandom_range(0, 3) == 0 ? AW'($urandom) : AW'($urandom_range(0, 3) * 4);
  endfunction
  initial begin
    wr_t e;
    wait (mon_on);
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("wr_en", 64'(bus.wr_en), 1);
        chk("wr_addr", 64'(bus.wr_addr), 64'(e.rd));
        chk("wr_data", 64'(bus.wr_data), 64'(e.d));
      end else chk("wr_en_idle", 64'(bus.wr_en), 0);
    end
  end
  initial begin
    drive(1, 5, 32'h55, 0, 0, 0);
    step();
    step();
    chk("rst_wr_en", 64'(bus.wr_en), 0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 0);
    chk("rst_wr_data", 64'(bus.wr_data), 0);
    chk("rst_md_ready", 64'(bus.md_ready), 1);
    nrst = 1;
    mon_on = 1;
    drive(1, 5, 32'h11, 0, 0, 0); step();
    drive(1, 6, 32'h22, 0, 0, 0); step();
    drive(1, 7, 32'h33, 0, 0, 0); step();
    drive(0, 0, 0, 1, 9, 32'hDEADBEEF); step();
    drive(0, 0, 0, 0, 0, 0); repeat (3) step();
    drive(0, 0, 0, 1, 3, 32'h333); step();
    drive(1, 4, 32'h400, 0, 0, 0); repeat (8) step();
    drive(0, 0, 0, 1, 8, 32'hA); step();
    drive(1, 8, 32'hB, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); repeat (2) step();
    drive(0, 0, 0, 1, 12, 32'hC); step();
    drive(1, 0, 32'hF0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 0, 32'hBAD); step();
    drive(0, 0, 0, 0, 0, 0); repeat (3) step();
    drive(0, 0, 0, 1, 20, 32'h20); step();
    drive(1, 21, 32'h21, 0, 0, 0); repeat (2) step();
    nrst = 0; drive(0, 0, 0, 0, 0, 0); step();
    nrst = 1; repeat (3) step();
    for (int i = 0; i < 3000; i++) begin
      if (!bus.pipe_valid || p_acc) begin
        bus.pipe_valid = $urandom_range(0, 9) < 7;
        bus.pipe_rd = pick();
        bus.pipe_data = $urandom;
      end
      if (!bus.md_valid || md_acc) begin
        bus.md_valid = $urandom_range(0, 9) < 3;
        bus.md_rd = pick();
        bus.md_data = $urandom;
      end
      nrst = (i % 700 != 699);
      if (!nrst) bus.md_valid = 0;
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (8) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
